lock_server: RTL

Ring-attached lock responder and authoritative owner table for the 64 system-wide locks. It sits as one station on the message ring and forwards every slot with one cycle of registered latency. It responds to `Lock` request slots from cores by granting the lock (forwarding `Lock` unmodified and recording the owner) or refusing it (rewriting to `LockFail`). It consumes `Unlock` slots to free entries, and exposes the table to its local CPU as a read/clear I/O device for debug and recovery.

---
 rtl/ring_pkg.sv | 18 +
 rtl/lock_owner_table.sv | 28 ++
 rtl/lock_server.sv | 146 ++++++++++++++
 3 files changed

// File: rtl/ring_pkg.sv
// Shared ring definitions: slot type codes, lock count and the owner-table entry layout.
// Pure declarations; no timing or flow control.
package ring_pkg;

  localparam int NLOCKS = 64;

  localparam logic [3:0] SLOT_TOKEN    = 4'd1;
  localparam logic [3:0] SLOT_NULL     = 4'd7;
  localparam logic [3:0] SLOT_LOCK     = 4'd9;
  localparam logic [3:0] SLOT_LOCKFAIL = 4'd10;
  localparam logic [3:0] SLOT_UNLOCK   = 4'd11;

  typedef struct packed {
    logic       valid;
    logic [3:0] owner;
  } lock_entry_t;

endpackage

// File: rtl/lock_owner_table.sv
// 64x5 lock owner RAM: one clocked write port, combinational read ports for the ring and the CPU.
// A write is visible to both read ports in the cycle after its clock edge; never stalls.
module lock_owner_table
  import ring_pkg::*;
(
  input  logic       clock,
  input  logic       we,
  input  logic [5:0] waddr,
  input  logic [4:0] wdata,
  input  logic [5:0] raddr_ring,
  output logic [4:0] rdata_ring,
  input  logic [5:0] raddr_io,
  output logic [4:0] rdata_io
);

  logic [4:0] mem_q [NLOCKS];

  // No reset: the owning FSM sweeps every entry to zero after reset.
  always_ff @(posedge clock) begin
    if (we) begin
      mem_q[waddr] <= wdata;
    end
  end

  assign rdata_ring = mem_q[raddr_ring];
  assign rdata_io   = mem_q[raddr_io];

endmodule

// File: rtl/lock_server.sv
// Ring lock station: grants/refuses Lock slots, consumes Unlocks, exposes the owner table as an I/O device.
// Ring path is one registered cycle; CPU I/O answers combinationally but stalls in INIT or on a ring write.
module lock_server
  import ring_pkg::*;
#(
  parameter logic [3:0] SRVID = 4'd14
) (
  input  logic        clock,
  input  logic        reset,
  input  logic [31:0] RingIn,
  input  logic [3:0]  SlotTypeIn,
  input  logic [3:0]  SrcDestIn,
  output logic [31:0] RingOut,
  output logic [3:0]  SlotTypeOut,
  output logic [3:0]  SrcDestOut,
  input  logic [8:3]  aq,
  input  logic        read,
  input  logic        selLockSrv,
  output logic [31:0] rqLockSrv,
  output logic        wrq,
  output logic        done,
  output logic        initBusy
);

  localparam logic STATE_INIT = 1'b0;
  localparam logic STATE_RUN  = 1'b1;

  logic        state_q, state_d;
  logic [5:0]  sweep_q, sweep_d;
  logic [15:0] fail_cnt_q, fail_cnt_d;
  logic [31:0] ring_out_q, ring_out_d;
  logic [3:0]  slot_type_q, slot_type_d;
  logic [3:0]  src_dest_q, src_dest_d;

  lock_entry_t ring_entry, io_entry;
  lock_entry_t ring_wdata, tbl_wdata;
  logic        ring_we, tbl_we;
  logic [5:0]  tbl_waddr;
  logic        is_run, io_rd_req, io_wr_req;

  lock_owner_table u_table (
    .clock      (clock),
    .we         (tbl_we),
    .waddr      (tbl_waddr),
    .wdata      (tbl_wdata),
    .raddr_ring (RingIn[5:0]),
    .rdata_ring (ring_entry),
    .raddr_io   (aq),
    .rdata_io   (io_entry)
  );

  assign is_run    = (state_q == STATE_RUN);
  assign io_rd_req = selLockSrv & read & is_run;
  assign io_wr_req = selLockSrv & ~read & is_run;

  always_comb begin
    ring_out_d  = RingIn;
    slot_type_d = SlotTypeIn;
    src_dest_d  = SrcDestIn;
    fail_cnt_d  = fail_cnt_q;
    ring_we     = 1'b0;
    ring_wdata  = '0;
    case (SlotTypeIn)
      SLOT_LOCK: begin
        if (!is_run) begin
          slot_type_d = SLOT_LOCKFAIL;
        end else if (!ring_entry.valid) begin
          ring_we    = 1'b1;
          ring_wdata = '{valid: 1'b1, owner: SrcDestIn};
        end else if (ring_entry.owner != SrcDestIn) begin
          slot_type_d = SLOT_LOCKFAIL;
          if (fail_cnt_q != 16'hFFFF) begin
            fail_cnt_d = fail_cnt_q + 16'd1;
          end
        end
      end
      SLOT_UNLOCK: begin
        if (RingIn[11:8] == SRVID) begin
          slot_type_d = SLOT_NULL;
          ring_out_d  = '0;
          src_dest_d  = '0;
          if (is_run && ring_entry.valid && (ring_entry.owner == SrcDestIn)) begin
            ring_we = 1'b1;
          end
        end
      end
      default: ;
    endcase
  end

  // Single write port: sweep in INIT, otherwise the ring beats a CPU clear.
  always_comb begin
    tbl_we    = 1'b0;
    tbl_waddr = '0;
    tbl_wdata = '0;
    if (!is_run) begin
      tbl_we    = 1'b1;
      tbl_waddr = sweep_q;
    end else if (ring_we) begin
      tbl_we    = 1'b1;
      tbl_waddr = RingIn[5:0];
      tbl_wdata = ring_wdata;
    end else if (io_wr_req) begin
      tbl_we    = 1'b1;
      tbl_waddr = aq;
    end
  end

  always_comb begin
    state_d = state_q;
    sweep_d = sweep_q;
    if (!is_run) begin
      sweep_d = sweep_q + 6'd1;
      if (sweep_q == 6'd63) begin
        state_d = STATE_RUN;
      end
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q     <= STATE_INIT;
      sweep_q     <= '0;
      fail_cnt_q  <= '0;
      ring_out_q  <= '0;
      slot_type_q <= SLOT_NULL;
      src_dest_q  <= '0;
    end else begin
      state_q     <= state_d;
      sweep_q     <= sweep_d;
      fail_cnt_q  <= fail_cnt_d;
      ring_out_q  <= ring_out_d;
      slot_type_q <= slot_type_d;
      src_dest_q  <= src_dest_d;
    end
  end

  assign RingOut     = ring_out_q;
  assign SlotTypeOut = slot_type_q;
  assign SrcDestOut  = src_dest_q;
  assign initBusy    = ~is_run;
  assign wrq         = io_rd_req;
  assign done        = io_rd_req | (io_wr_req & ~ring_we);
  assign rqLockSrv   = io_rd_req ? {fail_cnt_q, 11'b0, io_entry.valid, io_entry.owner} : 32'h0;

endmodule
